// File: rtl/game_ctrl_pkg.sv
// Purpose : shared Pong definitions (VGA frame-tick positions, FSM codes, default timing).
// Latency : n/a (constants, types and a helper function only).
// Backpr. : n/a.
// The score/overlay renderer imports this package to decode o_State identically.
package game_ctrl_pkg;

   // 640x480 timing positions used by the game sequencer
   localparam logic [9:0] H_VISIBLE_AREA = 10'd640;
   localparam logic [9:0] H_MAX          = 10'd799;
   localparam logic [9:0] V_PULSE_HEAD   = 10'd490;
   localparam logic [9:0] V_PULSE_TAIL   = 10'd491;

   // Default game timing
   localparam int DEF_SERVE_FRAMES = 60;
   localparam int DEF_POINT_FRAMES = 90;
   localparam int DEF_WIN_SCORE    = 9;
   localparam int DEF_HIT_HOLDOFF  = 8;

   // Frame counter width; covers either pause length up to 255 frames
   localparam int FCNT_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SERVE    = 3'd1,
      ST_PLAY     = 3'd2,
      ST_POINT    = 3'd3,
      ST_GAMEOVER = 3'd4
   } state_t;

   // Sticky per-frame events gathered from the pixel stream
   typedef struct packed {
      logic coll;
      logic miss_l;
      logic miss_r;
   } flags_t;

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/game_ctrl_detect.sv
// Purpose : sticky collision / miss flags per frame, plus post-hit collision holdoff.
// Latency : a pixel event is visible on o_Flags the cycle after it occurs; flags clear on the frame tick.
// Backpr. : none; the pixel stream is free-running.
// Ports   : i_Clk, i_Rst_L (async low); i_Frame tick, i_Play (FSM in PLAY), i_Hit_Load
//           (load holdoff); i_HSync_Pos, i_Ball_Video, i_Paddle_Video; o_Flags (coll/miss_l/miss_r).
module game_ctrl_detect
   import game_ctrl_pkg::*;
#(
   parameter int p_HIT_HOLDOFF = DEF_HIT_HOLDOFF
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_Frame,
   input  logic       i_Play,
   input  logic       i_Hit_Load,
   input  logic [9:0] i_HSync_Pos,
   input  logic       i_Ball_Video,
   input  logic       i_Paddle_Video,
   output flags_t     o_Flags
);

   localparam int HW = (p_HIT_HOLDOFF < 1) ? 1 : $clog2(p_HIT_HOLDOFF + 1);

   flags_t        r_Flags;
   logic [HW-1:0] r_Holdoff;
   logic          w_Coll;
   logic          w_Miss_L;
   logic          w_Miss_R;

   // Collisions are masked for the whole holdoff window so one paddle contact
   // spanning several frames produces a single hit.
   assign w_Coll   = i_Ball_Video & i_Paddle_Video & (r_Holdoff == '0);
   assign w_Miss_L = i_Ball_Video & (i_HSync_Pos == 10'd0);
   assign w_Miss_R = i_Ball_Video & (i_HSync_Pos == H_VISIBLE_AREA - 10'd1);

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_Flags   <= '0;
         r_Holdoff <= '0;
      end else if (!i_Play) begin
         // Nothing accumulates outside PLAY, and leaving PLAY drops any holdoff
         r_Flags   <= '0;
         r_Holdoff <= '0;
      end else if (i_Frame) begin
         r_Flags <= '0;
         if (i_Hit_Load)
            r_Holdoff <= HW'(p_HIT_HOLDOFF);
         else if (r_Holdoff != '0)
            r_Holdoff <= r_Holdoff - HW'(1);
      end else begin
         r_Flags.coll   <= r_Flags.coll   | w_Coll;
         r_Flags.miss_l <= r_Flags.miss_l | w_Miss_L;
         r_Flags.miss_r <= r_Flags.miss_r | w_Miss_R;
      end
   end

   assign o_Flags = r_Flags;

endmodule

// File: rtl/game_ctrl.sv
// Purpose : Pong sequencer: serve/point pauses, frame-aligned hit requests, scores, game over.
// Latency : all outputs registered; they change only on the cycle after the frame tick.
// Backpr. : none; i_Start edges are latched and consumed at the next frame tick.
// Ports   : i_Clk, i_Rst_L (async low); i_HSync_Pos/i_VSync_Pos pixel position; i_Ball_Video,
//           i_Paddle_Video; i_Start button level; o_Hit, o_Ball_Hold, o_Serve_Dir, o_Score_L/R,
//           o_State, o_Game_Over.
// Config  : GAME_CTRL_AUTOSERVE_EN defined -> SERVE ends after the countdown alone;
//           undefined -> SERVE also waits for an i_Start edge after the countdown.
module game_ctrl
   import game_ctrl_pkg::*;
#(
   parameter int p_SERVE_FRAMES = DEF_SERVE_FRAMES,
   parameter int p_POINT_FRAMES = DEF_POINT_FRAMES,
   parameter int p_WIN_SCORE    = DEF_WIN_SCORE,
   parameter int p_HIT_HOLDOFF  = DEF_HIT_HOLDOFF
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic [9:0] i_HSync_Pos,
   input  logic [9:0] i_VSync_Pos,
   input  logic       i_Ball_Video,
   input  logic       i_Paddle_Video,
   input  logic       i_Start,
   output logic       o_Hit,
   output logic       o_Ball_Hold,
   output logic       o_Serve_Dir,
   output logic [3:0] o_Score_L,
   output logic [3:0] o_Score_R,
   output logic [2:0] o_State,
   output logic       o_Game_Over
);

   state_t            r_State, w_State_Nxt;
   logic [FCNT_W-1:0] r_Fcnt, w_Fcnt_Nxt;
   logic [3:0]        r_Score_L, r_Score_R, w_Score_L_Nxt, w_Score_R_Nxt;
   logic [3:0]        w_Inc_L, w_Inc_R;
   logic              r_Serve_Dir, w_Serve_Dir_Nxt;
   logic              r_Hit, w_Hit_Nxt;
   logic              r_Hold, r_Game_Over;
   logic              r_Start_Q, r_Start_Seen;
   logic              w_Frame, w_Play, w_Start_Rise, w_Hit_Load;
   flags_t            w_Flags;

   // Same instant the ball block applies its horizontal step
   assign w_Frame      = (i_VSync_Pos == V_PULSE_TAIL) && (i_HSync_Pos == H_MAX);
   assign w_Play       = (r_State == ST_PLAY);
   assign w_Start_Rise = i_Start & ~r_Start_Q;
   assign w_Inc_L      = sat_inc(r_Score_L);
   assign w_Inc_R      = sat_inc(r_Score_R);
   assign w_Hit_Load   = w_Frame & w_Hit_Nxt;

   game_ctrl_detect #(.p_HIT_HOLDOFF(p_HIT_HOLDOFF)) u_detect (
      .i_Clk          (i_Clk),
      .i_Rst_L        (i_Rst_L),
      .i_Frame        (w_Frame),
      .i_Play         (w_Play),
      .i_Hit_Load     (w_Hit_Load),
      .i_HSync_Pos    (i_HSync_Pos),
      .i_Ball_Video   (i_Ball_Video),
      .i_Paddle_Video (i_Paddle_Video),
      .o_Flags        (w_Flags)
   );

   // Next-state values assume a frame tick; the register block applies them only on w_Frame.
   always_comb begin
      w_State_Nxt     = r_State;
      w_Fcnt_Nxt      = r_Fcnt;
      w_Score_L_Nxt   = r_Score_L;
      w_Score_R_Nxt   = r_Score_R;
      w_Serve_Dir_Nxt = r_Serve_Dir;
      w_Hit_Nxt       = 1'b0;
      case (r_State)
         ST_IDLE: begin
            if (r_Start_Seen) begin
               w_State_Nxt   = ST_SERVE;
               w_Score_L_Nxt = 4'd0;
               w_Score_R_Nxt = 4'd0;
               w_Fcnt_Nxt    = '0;
            end
         end
         ST_SERVE: begin
`ifdef GAME_CTRL_AUTOSERVE_EN
            if (r_Fcnt == FCNT_W'(p_SERVE_FRAMES - 1)) begin
               w_State_Nxt = ST_PLAY;
               w_Fcnt_Nxt  = '0;
            end else begin
               w_Fcnt_Nxt = r_Fcnt + FCNT_W'(1);
            end
`else
            // Counter parks at p_SERVE_FRAMES once expired; only an edge latched
            // in a later frame releases the ball.
            if (r_Fcnt == FCNT_W'(p_SERVE_FRAMES)) begin
               if (r_Start_Seen) begin
                  w_State_Nxt = ST_PLAY;
                  w_Fcnt_Nxt  = '0;
               end
            end else begin
               w_Fcnt_Nxt = r_Fcnt + FCNT_W'(1);
            end
`endif
         end
         ST_PLAY: begin
            w_Fcnt_Nxt = '0;
            // Left miss outranks right miss, and any miss suppresses the hit
            if (w_Flags.miss_l) begin
               w_Score_R_Nxt   = w_Inc_R;
               w_Serve_Dir_Nxt = 1'b0;
               w_State_Nxt     = (w_Inc_R == 4'(p_WIN_SCORE)) ? ST_GAMEOVER : ST_POINT;
            end else if (w_Flags.miss_r) begin
               w_Score_L_Nxt   = w_Inc_L;
               w_Serve_Dir_Nxt = 1'b1;
               w_State_Nxt     = (w_Inc_L == 4'(p_WIN_SCORE)) ? ST_GAMEOVER : ST_POINT;
            end else if (w_Flags.coll) begin
               w_Hit_Nxt = 1'b1;
            end
         end
         ST_POINT: begin
            if (r_Fcnt == FCNT_W'(p_POINT_FRAMES - 1)) begin
               w_State_Nxt = ST_SERVE;
               w_Fcnt_Nxt  = '0;
            end else begin
               w_Fcnt_Nxt = r_Fcnt + FCNT_W'(1);
            end
         end
         ST_GAMEOVER: begin
            if (r_Start_Seen)
               w_State_Nxt = ST_IDLE;
         end
         default: begin
            w_State_Nxt = ST_IDLE;
            w_Fcnt_Nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_State      <= ST_IDLE;
         r_Fcnt       <= '0;
         r_Score_L    <= 4'd0;
         r_Score_R    <= 4'd0;
         r_Serve_Dir  <= 1'b1;
         r_Hit        <= 1'b0;
         r_Hold       <= 1'b1;
         r_Game_Over  <= 1'b0;
         r_Start_Q    <= 1'b0;
         r_Start_Seen <= 1'b0;
      end else begin
         r_Start_Q <= i_Start;
         if (w_Frame) begin
            r_State      <= w_State_Nxt;
            r_Fcnt       <= w_Fcnt_Nxt;
            r_Score_L    <= w_Score_L_Nxt;
            r_Score_R    <= w_Score_R_Nxt;
            r_Serve_Dir  <= w_Serve_Dir_Nxt;
            r_Hit        <= w_Hit_Nxt;
            r_Hold       <= (w_State_Nxt != ST_PLAY);
            r_Game_Over  <= (w_State_Nxt == ST_GAMEOVER);
            r_Start_Seen <= 1'b0;
         end else if (w_Start_Rise) begin
            r_Start_Seen <= 1'b1;
         end
      end
   end

   assign o_Hit       = r_Hit;
   assign o_Ball_Hold = r_Hold;
   assign o_Serve_Dir = r_Serve_Dir;
   assign o_Score_L   = r_Score_L;
   assign o_Score_R   = r_Score_R;
   assign o_State     = r_State;
   assign o_Game_Over = r_Game_Over;

endmodule

// File: tb/tb_game_ctrl.sv
// Purpose : self-checking bench for game_ctrl using short synthetic frames and a frame-level model.
// Latency : each bench frame is 8 pixel clocks, the last one being the frame tick position.
// Backpr. : n/a.
module tb_game_ctrl;

   localparam int SERVE_N = 60;
   localparam int POINT_N = 90;
   localparam int WIN     = 9;
   localparam int HOLD    = 8;
   localparam logic [9:0] TICK_H  = 10'd799;
   localparam logic [9:0] TICK_V  = 10'd491;
   localparam logic [9:0] RIGHT_H = 10'd639;
   localparam logic [14:0] RST_VEC = 15'h3000;  // hold=1, dir=1, all else 0

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] hpos, vpos;
   logic       ball, pad, start;
   logic       o_Hit, o_Ball_Hold, o_Serve_Dir, o_Game_Over;
   logic [3:0] o_Score_L, o_Score_R;
   logic [2:0] o_State;

   always #5 clk = ~clk;

   game_ctrl dut (
      .i_Clk          (clk),
      .i_Rst_L        (rst_n),
      .i_HSync_Pos    (hpos),
      .i_VSync_Pos    (vpos),
      .i_Ball_Video   (ball),
      .i_Paddle_Video (pad),
      .i_Start        (start),
      .o_Hit          (o_Hit),
      .o_Ball_Hold    (o_Ball_Hold),
      .o_Serve_Dir    (o_Serve_Dir),
      .o_Score_L      (o_Score_L),
      .o_Score_R      (o_Score_R),
      .o_State        (o_State),
      .o_Game_Over    (o_Game_Over)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   // State numbers are the published o_State codes; ticks counts frame ticks spent in the state.
   int m_state, m_ticks, m_sl, m_sr, m_holdoff;
   bit m_hit, m_hold, m_dir, m_go;

   task automatic model_reset();
      m_state = 0; m_ticks = 0; m_sl = 0; m_sr = 0; m_holdoff = 0;
      m_hit = 0; m_hold = 1; m_dir = 1; m_go = 0;
   endtask

   // One frame of events, resolved at its closing tick
   task automatic model_frame(input bit press, input bit coll, input bit ml, input bit mr);
      int nxt;
      bit hit;
      nxt = m_state;
      hit = 0;
      case (m_state)
         0: if (press) begin nxt = 1; m_sl = 0; m_sr = 0; end
         1: begin
            m_ticks++;
`ifdef GAME_CTRL_AUTOSERVE_EN
            if (m_ticks == SERVE_N) nxt = 2;
`else
            if (m_ticks > SERVE_N && press) nxt = 2;
`endif
         end
         2: begin
            if (ml) begin
               m_sr = (m_sr < 15) ? m_sr + 1 : 15;
               m_dir = 0;
               nxt = (m_sr == WIN) ? 4 : 3;
            end else if (mr) begin
               m_sl = (m_sl < 15) ? m_sl + 1 : 15;
               m_dir = 1;
               nxt = (m_sl == WIN) ? 4 : 3;
            end else begin
               hit = coll && (m_holdoff == 0);
            end
            m_holdoff = hit ? HOLD : ((m_holdoff > 0) ? m_holdoff - 1 : 0);
         end
         3: begin
            m_ticks++;
            if (m_ticks == POINT_N) nxt = 1;
         end
         4: if (press) nxt = 0;
         default: nxt = 0;
      endcase
      if (nxt != m_state) begin
         m_ticks = 0;
         if (m_state == 2) m_holdoff = 0;
      end
      m_state = nxt;
      m_hit   = hit;
      m_hold  = (nxt != 2);
      m_go    = (nxt == 4);
   endtask

   function automatic logic [14:0] m_vec();
      return {m_hit, m_hold, m_dir, 4'(m_sl), 4'(m_sr), 3'(m_state), m_go};
   endfunction

   function automatic logic [14:0] dut_vec();
      return {o_Hit, o_Ball_Hold, o_Serve_Dir, o_Score_L, o_Score_R, o_State, o_Game_Over};
   endfunction

   // ---------------- stimulus ----------------
   task automatic step(input logic [9:0] h, input logic [9:0] v, input logic b,
                       input logic p, input logic s);
      hpos = h; vpos = v; ball = b; pad = p; start = s;
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input bit press, input bit coll, input bit ml, input bit mr);
      step(10'd100, 10'd100, 1'b0, 1'b0, 1'b0);
      step(10'd100, 10'd100, 1'b0, 1'b0, press);
      step(10'd200, 10'd100, coll, coll, 1'b0);
      step(10'd201, 10'd100, coll, coll, 1'b0);
      step(10'd202, 10'd100, coll, coll, 1'b0);
      step(10'd0,   10'd100, ml,   1'b0, 1'b0);
      step(RIGHT_H, 10'd100, mr,   1'b0, 1'b0);
      chk("stable_mid_frame", dut_vec(), m_vec());
      step(TICK_H, TICK_V, 1'b0, 1'b0, 1'b0);
      model_frame(press, coll, ml, mr);
      chk("after_tick", dut_vec(), m_vec());
   endtask

   task automatic quiet(input int n);
      for (int i = 0; i < n; i++) frame(0, 0, 0, 0);
   endtask

   task automatic to_play();
      int guard;
      bit p;
      guard = 0;
      while (m_state != 2 && guard < 400) begin
         p = (m_state == 0) || (m_state == 4) || (m_state == 1 && m_ticks >= SERVE_N);
         frame(p, 0, 0, 0);
         guard++;
      end
      chk("reach_play", 32'(o_State), 32'd2);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; hpos = '0; vpos = '0; ball = 0; pad = 0; start = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_vec", 32'(dut_vec()), 32'(RST_VEC));
      rst_n = 1'b1;
      step(10'd5, 10'd5, 1'b0, 1'b0, 1'b0);

      // Start -> SERVE on the next tick, then the countdown
      frame(1, 0, 0, 0);
      chk("serve_entry", 32'(o_State), 32'd1);
      chk("serve_hold", 32'(o_Ball_Hold), 32'd1);
      for (int i = 1; i < SERVE_N; i++) frame(i == 30, 0, 0, 0);
      chk("serve_59", 32'(o_State), 32'd1);
      frame(0, 0, 0, 0);
`ifdef GAME_CTRL_AUTOSERVE_EN
      chk("serve_60_play", 32'(o_State), 32'd2);
`else
      chk("serve_60_stall", 32'(o_State), 32'd1);
      quiet(3);
      chk("serve_still_stall", 32'(o_State), 32'd1);
      frame(1, 0, 0, 0);
      chk("serve_btn_play", 32'(o_State), 32'd2);
`endif
      chk("play_no_hold", 32'(o_Ball_Hold), 32'd0);

      // Hit, single-frame pulse, holdoff, re-arm
      frame(0, 1, 0, 0);
      chk("hit_on", 32'(o_Hit), 32'd1);
      frame(0, 0, 0, 0);
      chk("hit_off", 32'(o_Hit), 32'd0);
      quiet(2);
      frame(0, 1, 0, 0);
      chk("hit_holdoff", 32'(o_Hit), 32'd0);
      quiet(5);
      frame(0, 1, 0, 0);
      chk("hit_rearm", 32'(o_Hit), 32'd1);

      // Miss left -> right player scores, POINT pause, SERVE
      frame(0, 0, 1, 0);
      chk("missl_score_r", 32'(o_Score_R), 32'd1);
      chk("missl_dir", 32'(o_Serve_Dir), 32'd0);
      chk("missl_point", 32'(o_State), 32'd3);
      quiet(POINT_N - 1);
      chk("point_89", 32'(o_State), 32'd3);
      frame(0, 0, 0, 0);
      chk("point_90_serve", 32'(o_State), 32'd1);

      // Left player to 8 then the winning point
      for (int k = 0; k < WIN - 1; k++) begin
         to_play();
         frame(0, 0, 0, 1);
      end
      chk("score_l_8", 32'(o_Score_L), 32'd8);
      chk("dir_right", 32'(o_Serve_Dir), 32'd1);
      to_play();
      frame(0, 0, 0, 1);
      chk("win_score", 32'(o_Score_L), 32'd9);
      chk("win_state", 32'(o_State), 32'd4);
      chk("win_go", 32'(o_Game_Over), 32'd1);
      frame(1, 0, 0, 0);
      chk("go_idle", 32'(o_State), 32'd0);
      chk("go_cleared", 32'(o_Game_Over), 32'd0);
      frame(1, 0, 0, 0);
      chk("new_game_scores", 32'({o_Score_L, o_Score_R}), 32'd0);

      // Priorities
      to_play();
      frame(0, 1, 1, 0);
      chk("miss_beats_hit", 32'(o_Hit), 32'd0);
      chk("miss_beats_hit_sr", 32'(o_Score_R), 32'd1);
      to_play();
      frame(0, 0, 1, 1);
      chk("left_wins_sr", 32'(o_Score_R), 32'd2);
      chk("left_wins_sl", 32'(o_Score_L), 32'd0);

      // Reach 3-2 in PLAY, then asynchronous reset between clock edges
      for (int k = 0; k < 3; k++) begin
         to_play();
         frame(0, 0, 0, 1);
      end
      to_play();
      chk("pre_rst_score", 32'({o_Score_L, o_Score_R}), 32'h32);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst", 32'(dut_vec()), 32'(RST_VEC));
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Randomized frames against the model
      for (int i = 0; i < 2500; i++) begin
         frame($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Pong game sequencer that owns the ball datapath. It watches the pixel stream for ball/paddle collisions and ball misses, and feeds one frame-aligned hit request per collision to the ball block. It also holds the ball at centre during serve and point pauses, and keeps both players' scores. It sits between the VGA timing generator and the ball/paddle/score renderers, and is clocked at pixel rate like them.

## Interface
- p_SERVE_FRAMES, 60: frames the ball is held at centre before play resumes.
- p_POINT_FRAMES, 90: pause frames after a point is scored.
- p_WIN_SCORE, 9: score that ends the game (1..15).
- p_HIT_HOLDOFF, 8: frames after a hit during which new collisions are ignored.

- i_Clk  in  1  pixel clock.
- i_Rst_L  in  1  asynchronous active-low reset.
- i_HSync_Pos  in  10  current column counter.
- i_VSync_Pos  in  10  current line counter.
- i_Ball_Video  in  1  ball pixel active.
- i_Paddle_Video  in  1  any paddle pixel active.
- i_Start  in  1  start/serve button, already synchronised, level.
- o_Hit  out  1  hit request to the ball; level, frame-aligned.
- o_Ball_Hold  out  1  ball forced to start position, no motion.
- o_Serve_Dir  out  1  horizontal serve direction (1 = right).
- o_Score_L  out  4  left player score.
- o_Score_R  out  4  right player score.
- o_State  out  3  FSM state code, for debug/overlay.
- o_Game_Over  out  1  high in GAMEOVER.

## Operation
- Frame tick F: one-cycle internal strobe when i_VSync_Pos == V_PULSE_TAIL and i_HSync_Pos == H_MAX. This is the same instant at which the ball applies its horizontal step.
- All state transitions, frame counters and score updates occur only on F.
- Collision: i_Ball_Video && i_Paddle_Video on any pixel sets a sticky flag. Ignored while the holdoff counter is nonzero.
- Miss left: i_Ball_Video at column 0 of the visible area. Miss right: i_Ball_Video at column H_VISIBLE_AREA-1. Both are sticky until F.
- FSM states (o_State codes):
  - IDLE(0): o_Ball_Hold=1. i_Start rising edge → SERVE; scores cleared to 0.
  - SERVE(1): o_Ball_Hold=1; frame counter runs. After p_SERVE_FRAMES ticks → PLAY.
  - PLAY(2): o_Ball_Hold=0.
    - On F with a miss-left flag: o_Score_R+1, o_Serve_Dir=0 (serve toward the loser).
    - On F with a miss-right flag: o_Score_L+1, o_Serve_Dir=1.
    - On either miss → POINT. If the incremented score equals p_WIN_SCORE → GAMEOVER instead.
  - POINT(3): o_Ball_Hold=1. After p_POINT_FRAMES ticks → SERVE.
  - GAMEOVER(4): o_Ball_Hold=1, o_Game_Over=1. i_Start rising edge → IDLE.
- Both miss flags set on the same F: the left miss wins and the right flag is discarded.
- Hit: if the collision flag is set on F in PLAY, o_Hit goes 1 for exactly the following frame and the holdoff counter loads p_HIT_HOLDOFF. Otherwise o_Hit=0.
- A miss and a hit on the same F: the miss takes priority and o_Hit stays 0.
- Scores saturate at 15. They are never compared beyond p_WIN_SCORE.
- All collision, miss and frame counters clear on leaving PLAY.

## Timing
- Reset (asynchronous, active-low) values: state IDLE, o_Hit=0, o_Ball_Hold=1, o_Serve_Dir=1, both scores 0, o_Game_Over=0, all counters and flags 0.
- All outputs are registered and change on the cycle after F.
- o_Hit is held from F+1 to the next F+1. It therefore covers the ball's direction-sample point at V_PULSE_HEAD, column 1.
- i_Start edge detection uses a 1-cycle registered copy. Latency from edge to state change is the next F.
- Reset asserted mid-game returns to reset values immediately. No partial score survives.

## Configuration
- GAME_CTRL_AUTOSERVE_EN defined: SERVE → PLAY after p_SERVE_FRAMES with no button.
- GAME_CTRL_AUTOSERVE_EN undefined: SERVE also requires an i_Start rising edge seen after the countdown expires. o_Ball_Hold stays 1 until that edge.

## Structure
- The frame-tick positions V_PULSE_TAIL, V_PULSE_HEAD, H_MAX and H_VISIBLE_AREA come from the shared VgaTiming.v include.
- FSM state codes and the default parameter values go in a new shared GameDefs.v, so the score/overlay renderer decodes o_State identically.
- One sub-module, game_ctrl_detect, holds the sticky collision/miss flags and the holdoff counter. The top contains the FSM, scores and frame counter.

## Test plan
- Reset release, then i_Start pulse → SERVE on the next F, o_Ball_Hold=1. Exactly 60 F ticks later → PLAY, o_Ball_Hold=0.
- In PLAY, overlap ball and paddle video for 3 pixels in one frame → o_Hit high for exactly one frame. A second overlap 4 frames later gives no o_Hit (holdoff 8).
- In PLAY, ball pixel at column 0 → o_Score_R 0→1, o_Serve_Dir=0, POINT for 90 frames, then SERVE.
- Score 8–0; drive a miss right → o_Score_L=9, GAMEOVER, o_Game_Over=1. i_Start → IDLE. Next i_Start → scores 0.
- Miss left and collision flagged in the same frame → score changes and o_Hit stays 0. Miss left and miss right in the same frame → only o_Score_R increments.
- Assert i_Rst_L low mid-PLAY at score 3–2 → all outputs return to reset values asynchronously. Also run with GAME_CTRL_AUTOSERVE_EN undefined: SERVE stalls until an i_Start edge arrives after the countdown.
